wb_openram_port_arbiter: RTL and testbench

- Single-clock arbiter that sits directly upstream of the dual-port OpenRAM Wishbone wrapper and feeds its port A / port B Wishbone inputs.
- Decodes each master's address against the RAM window.
- Forwards strobes to the wrapper and drives `writable_port_req`, which selects the master that owns the RAM's read/write port.
- Owner swaps happen only when both buses are idle, so the wrapper's muxes never switch mid-transaction.

---
 rtl/wb_openram_port_arbiter_pkg.sv | 19 +
 rtl/wb_openram_port_arbiter_if.sv | 41 ++++
 rtl/wb_openram_port_arbiter_inflight.sv | 53 +++++
 rtl/wb_openram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_openram_port_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_openram_port_arbiter_pkg.sv
// Shared types and sizing helpers for the OpenRAM dual-port Wishbone arbiter.
package openram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_A   = 2'd0,
        DRAIN_B = 2'd1,
        OWN_B   = 2'd2,
        DRAIN_A = 2'd3
    } arb_state_e;

    localparam int STATS_W = 16;

    function automatic int hold_w(input int hold_cycles);
        int w;
        w = $clog2(hold_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_openram_port_arbiter_if.sv
// Master-side and wrapper-side Wishbone signals for both arbiter ports.
interface wb_openram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 8
);
    import openram_arb_pkg::*;

    logic                  wbm_a_cyc_i;
    logic                  wbm_a_stb_i;
    logic                  wbm_a_we_i;
    logic [31:0]           wbm_a_adr_i;
    logic                  wbm_b_cyc_i;
    logic                  wbm_b_stb_i;
    logic                  wbm_b_we_i;
    logic [31:0]           wbm_b_adr_i;

    logic                  wbs_a_cyc_o;
    logic                  wbs_a_stb_o;
    logic [ADDR_WIDTH+1:0] wbs_a_adr_o;
    logic                  wbs_a_ack_i;
    logic                  wbs_b_cyc_o;
    logic                  wbs_b_stb_o;
    logic [ADDR_WIDTH+1:0] wbs_b_adr_o;
    logic                  wbs_b_ack_i;

    modport slave (
        input  wbm_a_cyc_i, wbm_a_stb_i, wbm_a_we_i, wbm_a_adr_i,
        input  wbm_b_cyc_i, wbm_b_stb_i, wbm_b_we_i, wbm_b_adr_i,
        input  wbs_a_ack_i, wbs_b_ack_i,
        output wbs_a_cyc_o, wbs_a_stb_o, wbs_a_adr_o,
        output wbs_b_cyc_o, wbs_b_stb_o, wbs_b_adr_o
    );

    modport master (
        output wbm_a_cyc_i, wbm_a_stb_i, wbm_a_we_i, wbm_a_adr_i,
        output wbm_b_cyc_i, wbm_b_stb_i, wbm_b_we_i, wbm_b_adr_i,
        output wbs_a_ack_i, wbs_b_ack_i,
        input  wbs_a_cyc_o, wbs_a_stb_o, wbs_a_adr_o,
        input  wbs_b_cyc_o, wbs_b_stb_o, wbs_b_adr_o
    );

endinterface

// File: rtl/wb_openram_port_arbiter_inflight.sv
// Per-port window decode, inflight flag and new-start gating.
module wb_inflight_tracker
    import openram_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h30c0_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cyc,
    input  logic                  i_stb,
    input  logic                  i_we,
    input  logic [31:0]           i_adr,
    input  logic                  i_ack,
    input  logic                  i_is_owner,
    input  logic                  i_freeze,
    output logic                  o_cyc,
    output logic                  o_stb,
    output logic [ADDR_WIDTH+1:0] o_adr,
    output logic                  o_inflight,
    output logic                  o_pend_write
);

    logic r_inflight;
    logic w_in_win;
    logic w_hit;
    logic w_start_ok;
    logic w_stb;

    assign w_in_win   = (i_adr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_hit      = i_cyc & i_stb & w_in_win;
    assign w_start_ok = w_hit & ~i_freeze & (i_is_owner | ~i_we);

    // A transfer already presented to the wrapper must never be withdrawn.
    assign w_stb = r_inflight ? i_stb : w_start_ok;

    assign o_stb        = w_stb & ~i_rst;
    assign o_cyc        = i_cyc & w_in_win & ~i_rst;
    assign o_adr        = i_adr[ADDR_WIDTH+1:0];
    assign o_inflight   = r_inflight;
    assign o_pend_write = w_hit & i_we & ~r_inflight & ~i_is_owner;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
        end else if (~i_cyc | i_ack) begin
            r_inflight <= 1'b0;
        end else if (w_stb) begin
            r_inflight <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_openram_port_arbiter.sv
// Write-port ownership arbiter in front of the dual-port OpenRAM Wishbone wrapper.
// Optional macro OPENRAM_ARB_STATS_EN adds a saturating swap counter output.
module wb_openram_port_arbiter
    import openram_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h30c0_0000,
    parameter int          HOLD_CYCLES = 4
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    wb_openram_port_arbiter_if.slave  bus,
    output logic                      writable_port_req,
    output logic                      switch_pending
`ifdef OPENRAM_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]        switch_count
`endif
);

    localparam int                HOLD_W    = hold_w(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_wpr;
    logic              w_wpr_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [HOLD_W-1:0] w_hold_dec;
    logic              w_freeze;
    logic              w_a_inflight;
    logic              w_b_inflight;
    logic              w_a_pend;
    logic              w_b_pend;

    wb_inflight_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_trk_a (
        .i_clk        (wb_clk_i),
        .i_rst        (wb_rst_i),
        .i_cyc        (bus.wbm_a_cyc_i),
        .i_stb        (bus.wbm_a_stb_i),
        .i_we         (bus.wbm_a_we_i),
        .i_adr        (bus.wbm_a_adr_i),
        .i_ack        (bus.wbs_a_ack_i),
        .i_is_owner   (~r_wpr),
        .i_freeze     (w_freeze),
        .o_cyc        (bus.wbs_a_cyc_o),
        .o_stb        (bus.wbs_a_stb_o),
        .o_adr        (bus.wbs_a_adr_o),
        .o_inflight   (w_a_inflight),
        .o_pend_write (w_a_pend)
    );

    wb_inflight_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_trk_b (
        .i_clk        (wb_clk_i),
        .i_rst        (wb_rst_i),
        .i_cyc        (bus.wbm_b_cyc_i),
        .i_stb        (bus.wbm_b_stb_i),
        .i_we         (bus.wbm_b_we_i),
        .i_adr        (bus.wbm_b_adr_i),
        .i_ack        (bus.wbs_b_ack_i),
        .i_is_owner   (r_wpr),
        .i_freeze     (w_freeze),
        .o_cyc        (bus.wbs_b_cyc_o),
        .o_stb        (bus.wbs_b_stb_o),
        .o_adr        (bus.wbs_b_adr_o),
        .o_inflight   (w_b_inflight),
        .o_pend_write (w_b_pend)
    );

    assign w_hold_dec = (r_hold == '0) ? '0 : (r_hold - HOLD_W'(1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= OWN_A;
            r_wpr   <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wpr   <= w_wpr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Freezing on the pre-emption cycle itself keeps the owner from slipping
    // in a new transfer on the same edge DRAIN is entered.
    always_comb begin
        w_state_nxt = r_state;
        w_wpr_nxt   = r_wpr;
        w_hold_nxt  = r_hold;
        w_freeze    = 1'b0;
        case (r_state)
            OWN_A: begin
                w_hold_nxt = w_hold_dec;
                if (w_b_pend && (r_hold == '0)) begin
                    w_state_nxt = DRAIN_B;
                    w_freeze    = 1'b1;
                end
            end
            DRAIN_B: begin
                w_freeze = 1'b1;
                if (!bus.wbm_b_cyc_i) begin
                    w_state_nxt = OWN_A;
                end else if (!w_a_inflight && !w_b_inflight) begin
                    w_state_nxt = OWN_B;
                    w_wpr_nxt   = 1'b1;
                    w_hold_nxt  = HOLD_INIT;
                end
            end
            OWN_B: begin
                w_hold_nxt = w_hold_dec;
                if (w_a_pend && (r_hold == '0)) begin
                    w_state_nxt = DRAIN_A;
                    w_freeze    = 1'b1;
                end
            end
            DRAIN_A: begin
                w_freeze = 1'b1;
                if (!bus.wbm_a_cyc_i) begin
                    w_state_nxt = OWN_B;
                end else if (!w_a_inflight && !w_b_inflight) begin
                    w_state_nxt = OWN_A;
                    w_wpr_nxt   = 1'b0;
                    w_hold_nxt  = HOLD_INIT;
                end
            end
            default: begin
                w_state_nxt = OWN_A;
            end
        endcase
    end

    assign writable_port_req = r_wpr;
    assign switch_pending    = (r_state == DRAIN_A) || (r_state == DRAIN_B);

`ifdef OPENRAM_ARB_STATS_EN
    logic [STATS_W-1:0] r_switch_count;

    // The owner flag only ever changes on a completed swap.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_switch_count <= '0;
        end else if ((w_wpr_nxt != r_wpr) && (r_switch_count != '1)) begin
            r_switch_count <= r_switch_count + STATS_W'(1);
        end
    end

    assign switch_count = r_switch_count;
`endif

endmodule

// File: tb/tb_wb_openram_port_arbiter.sv
// Directed and randomized checks of the OpenRAM port arbiter against a behavioural model.
module tb_wb_openram_port_arbiter;

    localparam int          AW       = 8;
    localparam logic [31:0] BASE     = 32'h30c0_0000;
    localparam int          HOLD     = 4;
    localparam logic [31:0] ADR_MASK = (32'd1 << (AW + 2)) - 32'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        wpr;
    logic        sp;
`ifdef OPENRAM_ARB_STATS_EN
    logic [15:0] sc;
`endif

    logic        t_cyc [2];
    logic        t_stb [2];
    logic        t_we  [2];
    logic        t_ack [2];
    logic [31:0] t_adr [2];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: who owns the write port, whether a handover
    // is pending, remaining hold time and which ports have a live transfer.
    int m_owner;
    bit m_drain;
    int m_hold;
    bit m_busy [2];
    int m_swaps;

    bit e_win  [2];
    bit e_hit  [2];
    bit e_want [2];
    bit e_stb  [2];
    bit e_cyc  [2];

    bit r_act  [2];
    bit r_done [2];
    int r_cnt  [2];
    int r_lat  [2];

    always #5 clk = ~clk;

    wb_openram_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    assign bus.wbm_a_cyc_i = t_cyc[0];
    assign bus.wbm_a_stb_i = t_stb[0];
    assign bus.wbm_a_we_i  = t_we[0];
    assign bus.wbm_a_adr_i = t_adr[0];
    assign bus.wbs_a_ack_i = t_ack[0];
    assign bus.wbm_b_cyc_i = t_cyc[1];
    assign bus.wbm_b_stb_i = t_stb[1];
    assign bus.wbm_b_we_i  = t_we[1];
    assign bus.wbm_b_adr_i = t_adr[1];
    assign bus.wbs_b_ack_i = t_ack[1];

    wb_openram_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (BASE),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .bus               (bus.slave),
        .writable_port_req (wpr),
        .switch_pending    (sp)
`ifdef OPENRAM_ARB_STATS_EN
        ,
        .switch_count      (sc)
`endif
    );

    function automatic bit in_win(input logic [31:0] a);
        return (a >> (AW + 2)) == (BASE >> (AW + 2));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int x, input bit c, input bit s, input bit w, input logic [31:0] a);
        t_cyc[x] = c;
        t_stb[x] = s;
        t_we[x]  = w;
        t_adr[x] = a;
    endtask

    task automatic m_reset();
        m_owner = 0;
        m_drain = 0;
        m_hold  = 0;
        m_busy[0] = 0;
        m_busy[1] = 0;
        m_swaps = 0;
    endtask

    task automatic eval_cycle();
        bit freeze;
        #1;
        for (int x = 0; x < 2; x++) begin
            e_win[x]  = in_win(t_adr[x]);
            e_hit[x]  = t_cyc[x] && t_stb[x] && e_win[x];
            e_want[x] = e_hit[x] && t_we[x] && !m_busy[x] && (x != m_owner) && !m_drain;
        end
        freeze = m_drain || (m_hold == 0 && e_want[1 - m_owner]);
        for (int x = 0; x < 2; x++) begin
            if (rst)            e_stb[x] = 0;
            else if (m_busy[x]) e_stb[x] = t_stb[x];
            else                e_stb[x] = e_hit[x] && !freeze && (x == m_owner || !t_we[x]);
            e_cyc[x] = !rst && t_cyc[x] && e_win[x];
        end
        chk("stb_a", bus.wbs_a_stb_o, e_stb[0]);
        chk("stb_b", bus.wbs_b_stb_o, e_stb[1]);
        chk("cyc_a", bus.wbs_a_cyc_o, e_cyc[0]);
        chk("cyc_b", bus.wbs_b_cyc_o, e_cyc[1]);
        chk("adr_a", bus.wbs_a_adr_o, t_adr[0] & ADR_MASK);
        chk("adr_b", bus.wbs_b_adr_o, t_adr[1] & ADR_MASK);
        chk("owner", wpr, m_owner);
        chk("pending", sp, m_drain);
`ifdef OPENRAM_ARB_STATS_EN
        chk("count", sc, m_swaps);
`endif
    endtask

    task automatic adv();
        bit nb [2];
        int o;
        if (rst) begin
            m_reset();
        end else begin
            for (int x = 0; x < 2; x++)
                nb[x] = (!t_cyc[x] || t_ack[x]) ? 1'b0 : (e_stb[x] ? 1'b1 : m_busy[x]);
            o = 1 - m_owner;
            if (!m_drain) begin
                if (m_hold == 0 && e_want[o]) m_drain = 1;
                if (m_hold > 0) m_hold--;
            end else if (!t_cyc[o]) begin
                m_drain = 0;
            end else if (!m_busy[0] && !m_busy[1]) begin
                m_owner = o;
                m_drain = 0;
                m_hold  = HOLD;
                if (m_swaps < 65535) m_swaps++;
            end
            m_busy[0] = nb[0];
            m_busy[1] = nb[1];
        end
        @(negedge clk);
    endtask

    task automatic tick();
        eval_cycle();
        adv();
    endtask

    task automatic do_write(input int x, input logic [31:0] a);
        bit granted = 0;
        bit done = 0;
        set_m(x, 1, 1, 1, a);
        for (int n = 0; n < 40 && !done; n++) begin
            if (granted) begin
                t_ack[x] = 1;
                eval_cycle();
                adv();
                t_ack[x] = 0;
                set_m(x, 0, 0, 0, 32'h0);
                done = 1;
            end else begin
                eval_cycle();
                if (e_stb[x]) granted = 1;
                adv();
            end
        end
        chk("write_done", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        for (int x = 0; x < 2; x++) begin
            set_m(x, 0, 0, 0, 32'h0);
            t_ack[x] = 0;
            r_act[x] = 0;
            r_cnt[x] = 0;
            r_lat[x] = 0;
        end
        repeat (2) @(negedge clk);
        m_reset();
        tick();
        rst = 0;

        // Reset state, then an owner write passes immediately
        eval_cycle();
        chk("rst_owner", wpr, 0);
        chk("rst_stb_a", bus.wbs_a_stb_o, 0);
        chk("rst_stb_b", bus.wbs_b_stb_o, 0);
        adv();
        set_m(0, 1, 1, 1, 32'h30c0_0010);
        eval_cycle();
        chk("a_wr_stb", bus.wbs_a_stb_o, 1);
        chk("a_wr_adr", bus.wbs_a_adr_o, 32'h010);
        adv();
        t_ack[0] = 1;
        tick();
        t_ack[0] = 0;
        set_m(0, 0, 0, 0, 32'h0);
        tick();

        // Non-owner write triggers a one-cycle drain and swap
        set_m(1, 1, 1, 1, 32'h30c0_0020);
        eval_cycle();
        chk("b_pend_stb", bus.wbs_b_stb_o, 0);
        adv();
        eval_cycle();
        chk("b_drain_sp", sp, 1);
        chk("b_drain_owner", wpr, 0);
        adv();
        eval_cycle();
        chk("b_swap_owner", wpr, 1);
        chk("b_swap_stb", bus.wbs_b_stb_o, 1);
        adv();
        t_ack[1] = 1;
        tick();
        t_ack[1] = 0;
        set_m(1, 0, 0, 0, 32'h0);
        tick();

        // In-flight read on A holds off the handover
        rst = 1;
        tick();
        rst = 0;
        set_m(0, 1, 1, 0, 32'h30c0_0040);
        eval_cycle();
        chk("inf_a_start", bus.wbs_a_stb_o, 1);
        adv();
        set_m(1, 1, 1, 1, 32'h30c0_0044);
        eval_cycle();
        chk("inf_a_hold", bus.wbs_a_stb_o, 1);
        chk("inf_b_block", bus.wbs_b_stb_o, 0);
        adv();
        t_ack[0] = 1;
        eval_cycle();
        chk("inf_sp", sp, 1);
        chk("inf_owner_ack", wpr, 0);
        chk("inf_a_ack_stb", bus.wbs_a_stb_o, 1);
        adv();
        t_ack[0] = 0;
        set_m(0, 0, 0, 0, 32'h0);
        eval_cycle();
        chk("inf_owner_post", wpr, 0);
        adv();
        eval_cycle();
        chk("inf_swap", wpr, 1);
        chk("inf_b_stb", bus.wbs_b_stb_o, 1);
        adv();

        // Hold window: B keeps writing while A waits
        set_m(0, 1, 1, 1, 32'h30c0_0080);
        for (int i = 0; i < 3; i++) begin
            t_ack[1] = (i % 2 == 0);
            eval_cycle();
            chk("hold_owner", wpr, 1);
            chk("hold_sp", sp, 0);
            chk("hold_b_stb", bus.wbs_b_stb_o, 1);
            chk("hold_a_blk", bus.wbs_a_stb_o, 0);
            adv();
        end
        t_ack[1] = 0;
        eval_cycle();
        chk("hold_b_preempt", bus.wbs_b_stb_o, 0);
        adv();
        eval_cycle();
        chk("hold_drain_sp", sp, 1);
        chk("hold_drain_b", bus.wbs_b_stb_o, 0);
        chk("hold_drain_own", wpr, 1);
        adv();
        set_m(1, 0, 0, 0, 32'h0);
        eval_cycle();
        chk("hold_a_owner", wpr, 0);
        chk("hold_a_stb", bus.wbs_a_stb_o, 1);
        adv();
        t_ack[0] = 1;
        tick();
        t_ack[0] = 0;
        set_m(0, 0, 0, 0, 32'h0);
        tick();

        // Window miss is never forwarded
        set_m(0, 1, 1, 1, 32'h3000_0000);
        for (int i = 0; i < 2; i++) begin
            eval_cycle();
            chk("miss_stb", bus.wbs_a_stb_o, 0);
            chk("miss_cyc", bus.wbs_a_cyc_o, 0);
            chk("miss_sp", sp, 0);
            adv();
        end
        set_m(0, 0, 0, 0, 32'h0);
        repeat (6) tick();

        // B abandons during the drain
        set_m(1, 1, 1, 1, 32'h30c0_0030);
        tick();
        set_m(1, 0, 0, 0, 32'h0);
        eval_cycle();
        chk("abort_sp", sp, 1);
        adv();
        eval_cycle();
        chk("abort_sp_clr", sp, 0);
        chk("abort_owner", wpr, 0);
        adv();

        // Reset in the middle of a drain, then three swaps
        set_m(1, 1, 1, 1, 32'h30c0_0030);
        tick();
        rst = 1;
        eval_cycle();
        chk("rd_sp_before", sp, 1);
        adv();
        rst = 0;
        set_m(1, 0, 0, 0, 32'h0);
        eval_cycle();
        chk("rd_sp", sp, 0);
        chk("rd_owner", wpr, 0);
`ifdef OPENRAM_ARB_STATS_EN
        chk("rd_count", sc, 0);
`endif
        adv();
        do_write(1, 32'h30c0_0100);
        do_write(0, 32'h30c0_0104);
        do_write(1, 32'h30c0_0108);
        eval_cycle();
        chk("swaps_owner", wpr, 1);
`ifdef OPENRAM_ARB_STATS_EN
        chk("swaps_count", sc, 3);
`endif
        adv();

        // Randomized traffic from both masters with a random-latency wrapper
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom % 300 == 0);
            for (int x = 0; x < 2; x++) begin
                t_ack[x]  = 0;
                r_done[x] = 0;
                if (r_act[x]) begin
                    if (m_busy[x] && r_cnt[x] >= r_lat[x]) begin
                        t_ack[x]  = 1;
                        r_done[x] = 1;
                    end else if ($urandom % 20 == 0) begin
                        set_m(x, 0, 0, 0, 32'h0);
                        r_act[x] = 0;
                    end
                end else begin
                    set_m(x, 0, 0, 0, 32'h0);
                    if ($urandom % 3 == 0) begin
                        r_act[x] = 1;
                        r_cnt[x] = 0;
                        r_lat[x] = $urandom_range(0, 2);
                        if ($urandom % 5 == 0)
                            set_m(x, 1, 1, $urandom % 2, $urandom);
                        else
                            set_m(x, 1, 1, $urandom % 2, BASE | ($urandom & 32'h3fc));
                    end
                end
                if (m_busy[x]) r_cnt[x]++;
            end
            eval_cycle();
            adv();
            for (int x = 0; x < 2; x++)
                if (r_done[x]) r_act[x] = 0;
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
